// File: rtl/cic_interp_param.sv
`default_nettype none
// ============================================================================
// Module   : cic_interp_param
// Purpose  : Parametrised Hogenauer CIC interpolator (N combs, zero-stuffer,
//            N integrators) in the clk_8 domain. Optional output clamp is
//            enabled by defining CIC_OUT_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cic_interp_param #(
  parameter int W_IN      = 11,
  parameter int LOG2_L    = 3,
  parameter int N         = 3,
  parameter int W_OUT     = 20,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk_8,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [W_IN-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [W_OUT-1:0] out_data,
  output logic                    out_valid,
  output logic                    underrun
);

  localparam int W_ACC = W_IN + N * LOG2_L;
  localparam int W_S   = W_ACC - OUT_SHIFT;

  logic [LOG2_L-1:0]       r_ph;
  logic                    w_slot;
  logic signed [W_ACC-1:0] w_c [0:N];
  logic signed [W_ACC-1:0] r_d [1:N];
  logic signed [W_ACC-1:0] r_u;
  logic signed [W_ACC-1:0] r_i [1:N];
  logic [N+1:0]            r_vpipe;
  logic signed [W_S-1:0]   w_s;
  logic signed [W_OUT-1:0] w_narrow;

  assign w_slot    = en & rst_n & (r_ph == '0);
  assign in_ready  = w_slot;
  assign out_valid = r_vpipe[N+1];

  // A missing sample at a slot enters the combs as zero
  assign w_c[0] = in_valid ? {{(W_ACC-W_IN){in_data[W_IN-1]}}, in_data} : '0;

  for (genvar gk = 1; gk <= N; gk++) begin : g_comb
    assign w_c[gk] = w_c[gk-1] - r_d[gk];
  end

  assign w_s = r_i[N][W_ACC-1:OUT_SHIFT];

  if (OUT_SHIFT > 0) begin : g_drop_lsb
    logic w_unused_lo;
    assign w_unused_lo = ^r_i[N][OUT_SHIFT-1:0];
  end

  if (W_OUT > W_S) begin : g_ext
    assign w_narrow = {{(W_OUT-W_S){w_s[W_S-1]}}, w_s};
  end else if (W_OUT == W_S) begin : g_same
    assign w_narrow = w_s;
  end else begin : g_narrow
`ifdef CIC_OUT_SAT_EN
    logic w_ovf;
    // Dropped MSBs must all equal the sign bit, otherwise clamp
    assign w_ovf    = (w_s[W_S-1:W_OUT-1] != {(W_S-W_OUT+1){w_s[W_S-1]}});
    assign w_narrow = !w_ovf      ? w_s[W_OUT-1:0] :
                      w_s[W_S-1]  ? {1'b1, {(W_OUT-1){1'b0}}} :
                                    {1'b0, {(W_OUT-1){1'b1}}};
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_s[W_S-1:W_OUT];
    assign w_narrow    = w_s[W_OUT-1:0];
`endif
  end

  always_ff @(posedge clk_8 or negedge rst_n) begin
    if (!rst_n) begin
      r_ph     <= '0;
      r_u      <= '0;
      r_vpipe  <= '0;
      out_data <= '0;
      underrun <= 1'b0;
      for (int k = 1; k <= N; k++) begin
        r_d[k] <= '0;
        r_i[k] <= '0;
      end
    end else if (!en) begin
      r_ph     <= '0;
      r_u      <= '0;
      r_vpipe  <= '0;
      out_data <= '0;
      underrun <= 1'b0;
      for (int k = 1; k <= N; k++) begin
        r_d[k] <= '0;
        r_i[k] <= '0;
      end
    end else begin
      r_ph     <= r_ph + 1'b1;
      r_vpipe  <= {r_vpipe[N:0], 1'b1};
      underrun <= w_slot & ~in_valid;
      out_data <= w_narrow;
      if (w_slot) begin
        r_u <= w_c[N];
        for (int k = 1; k <= N; k++) begin
          r_d[k] <= w_c[k-1];
        end
      end else begin
        r_u <= '0;
      end
      r_i[1] <= r_i[1] + r_u;
      for (int k = 2; k <= N; k++) begin
        r_i[k] <= r_i[k] + r_i[k-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cic_interp_param.md
# cic_interp_param

Parametrised CIC interpolator for the Tx interpolation chain: one input sample every L clk_8 cycles in, one filtered sample per clk_8 cycle out. Transfer function is ((1 − z^−L)/(1 − z^−1))^N, implemented in Hogenauer form: N low-rate combs, a zero-stuffer and N high-rate integrators, all in the clk_8 domain. It generalises the fixed 8-phase, 3rd-order, 11→20-bit comb interpolator to arbitrary rate, order and widths. It adds an input handshake, underrun detection, an output scaler and a run/clear control.

## Interface
- W_IN, 11, input sample width (signed)
- LOG2_L, 3, log2 of interpolation factor L (L = 2^LOG2_L)
- N, 3, CIC order (1..6)
- W_OUT, 20, output width (signed)
- OUT_SHIFT, 0, arithmetic right shift applied before narrowing to W_OUT
- Derived: W_ACC = W_IN + N·LOG2_L, internal datapath width

Ports:
- clk_8  in  1  high-rate clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; 0 = synchronous clear and hold idle
- in_data  in  W_IN  signed input sample
- in_valid  in  1  input sample present
- in_ready  out  1  high on the input slot cycle
- out_data  out  W_OUT  signed interpolated sample
- out_valid  out  1  out_data is a valid filter output
- underrun  out  1  one-cycle pulse when a slot passes with no sample

## Operation
- Phase counter ph (LOG2_L bits) increments every cycle while en=1 and wraps L−1→0. It is held at 0 while en=0.
- in_ready = en & (ph == 0). A slot occurs on every cycle with in_ready=1.
- **Accept.** in_valid & in_ready at a slot accepts in_data.
- **Underrun.** in_valid=0 at a slot injects a zero sample and pulses underrun on the next cycle. in_valid outside a slot is ignored.
- **Comb section.** Combs update only at slots. Stage k computes c_k = c_{k−1} − d_k, then d_k ← c_{k−1}. Combs use differential delay 1 at low rate, are combinational within the slot cycle, and operate on W_ACC bits sign-extended from in_data.
- **Zero-stuffer.** Register u ← comb output at a slot, else u ← 0.
- **Integrators.** Chain I_1..I_N, each registered: I_1 ← I_1 + u, I_k ← I_k + I_{k−1}. Two's-complement wrap at W_ACC; wrap is exact by construction.
- **Output.** s = I_N >>> OUT_SHIFT, narrowed to W_OUT (see Configuration), then registered into out_data.
- **out_valid.** Equals en delayed N+2 cycles, matching first-accepted-sample propagation.
- **en falls.** On the next edge, ph, every comb delay, u, every integrator, out_data and the out_valid pipeline clear to 0. The block then stays idle until en rises again; the first slot is the cycle en is sampled high.
- **Reset.** Async assertion clears everything. out_data=0, out_valid=0, in_ready=0, underrun=0.

## Timing
- Sample accepted at edge t: u holds it after t+1, I_N after t+N+1, out_data after t+N+2. Latency to first nonzero output is N+2 edges.
- Throughput: exactly one sample per L cycles. There is no back-pressure on the output.
- DC gain per output sample is L^(N−1). With default parameters this is 64.
- Impulse response length is N·(L−1)+1 output samples.

## Configuration
- CIC_OUT_SAT_EN defined: after the shift, values above 2^(W_OUT−1)−1 or below −2^(W_OUT−1) clamp to those limits.
- CIC_OUT_SAT_EN undefined: the W_OUT LSBs are kept (wrap). No clamp logic is present.
- When W_OUT ≥ W_ACC−OUT_SHIFT, the value is sign-extended and both builds behave identically.

## Test plan
- **Impulse (defaults).** One sample 1, then zeros at every slot → 22 outputs 1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1, then 0. The first value appears N+2=5 edges after accept.
- **DC.** Constant 100 at every slot → after 22 outputs, steady out_data=6400. Constant −1024 → steady −65536. No wrap; all values fit 20 bits.
- **Saturation, W_OUT=16, input DC 1023.** With CIC_OUT_SAT_EN → steady 32767. Without → steady −64 (65472 wrapped).
- **Underrun.** Drop in_valid for one slot during DC 100 → underrun pulses once. Output follows the response with one zero sample; no other stall.
- **en clear.** Deassert en mid-stream → next edge out_data=0, out_valid=0, in_ready=0. Re-enable and repeat the impulse → identical sequence, proving state was fully cleared.
- **Async reset.** Assert rst_n low between edges → all outputs 0 immediately. Also covers LOG2_L=2, N=4: impulse response is the 13 coefficients of (1+z^−1+z^−2+z^−3)^4, summing to 256.
